// File: rtl/axi_arb_pkg.sv
// Shared types and AXI3 field widths for the two-master read arbiter.
// The FSM state encoding is kept here so that every file uses the same one.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// When both masters request, the master that was not served last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one external AXI3 AR/R port between the data cache (s0) and the
// instruction cache (s1); one burst outstanding, round-robin between bursts.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               aclk,
  input  logic               rst,

  input  logic [ID_W-1:0]    s0_arid,
  input  logic [ADDR_W-1:0]  s0_araddr,
  input  logic [LEN_W-1:0]   s0_arlen,
  input  logic [SIZE_W-1:0]  s0_arsize,
  input  logic [BURST_W-1:0] s0_arburst,
  input  logic [LOCK_W-1:0]  s0_arlock,
  input  logic [CACHE_W-1:0] s0_arcache,
  input  logic [PROT_W-1:0]  s0_arprot,
  input  logic               s0_arvalid,
  output logic               s0_arready,
  output logic [ID_W-1:0]    s0_rid,
  output logic [DATA_W-1:0]  s0_rdata,
  output logic [RESP_W-1:0]  s0_rresp,
  output logic               s0_rlast,
  output logic               s0_rvalid,
  input  logic               s0_rready,

  input  logic [ID_W-1:0]    s1_arid,
  input  logic [ADDR_W-1:0]  s1_araddr,
  input  logic [LEN_W-1:0]   s1_arlen,
  input  logic [SIZE_W-1:0]  s1_arsize,
  input  logic [BURST_W-1:0] s1_arburst,
  input  logic [LOCK_W-1:0]  s1_arlock,
  input  logic [CACHE_W-1:0] s1_arcache,
  input  logic [PROT_W-1:0]  s1_arprot,
  input  logic               s1_arvalid,
  output logic               s1_arready,
  output logic [ID_W-1:0]    s1_rid,
  output logic [DATA_W-1:0]  s1_rdata,
  output logic [RESP_W-1:0]  s1_rresp,
  output logic               s1_rlast,
  output logic               s1_rvalid,
  input  logic               s1_rready,

  output logic [ID_W-1:0]    arid,
  output logic [ADDR_W-1:0]  araddr,
  output logic [LEN_W-1:0]   arlen,
  output logic [SIZE_W-1:0]  arsize,
  output logic [BURST_W-1:0] arburst,
  output logic [LOCK_W-1:0]  arlock,
  output logic [CACHE_W-1:0] arcache,
  output logic [PROT_W-1:0]  arprot,
  output logic               arvalid,
  input  logic               arready,

  input  logic [ID_W-1:0]    rid,
  input  logic [DATA_W-1:0]  rdata,
  input  logic [RESP_W-1:0]  rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,

  output logic               grant,
  output logic               busy
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_grant;
  logic       r_last_grant;
  logic       w_winner;
  logic [1:0] w_req;
  logic       w_arvalid;
  logic       w_rready;

  assign w_req = {s1_arvalid, s0_arvalid};

  rr_arb2 u_rr_arb2 (
    .req       (w_req),
    .last_grant(r_last_grant),
    .winner    (w_winner)
  );

  // Grant is only re-evaluated in IDLE, so a granted burst is never pre-empted.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_req != 2'b00) begin
        r_grant <= w_winner;
      end
      if (r_state == DATA && rvalid && w_rready && rlast) begin
        r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    s0_rid       = '0;
    s0_rdata     = '0;
    s0_rresp     = '0;
    s0_rlast     = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rid       = '0;
    s1_rdata     = '0;
    s1_rresp     = '0;
    s1_rlast     = 1'b0;
    s1_rvalid    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req != 2'b00) begin
          w_next_state = ADDR;
        end
      end

      // A granted master that drops arvalid early just stalls here.
      ADDR: begin
        w_arvalid  = r_grant ? s1_arvalid : s0_arvalid;
        s0_arready = ~r_grant & arready;
        s1_arready =  r_grant & arready;
        if (w_arvalid && arready) begin
          w_next_state = DATA;
        end
      end

      DATA: begin
        w_rready = r_grant ? s1_rready : s0_rready;
        if (r_grant) begin
          s1_rid    = rid;
          s1_rdata  = rdata;
          s1_rresp  = rresp;
          s1_rlast  = rlast;
          s1_rvalid = rvalid;
        end else begin
          s0_rid    = rid;
          s0_rdata  = rdata;
          s0_rresp  = rresp;
          s0_rlast  = rlast;
          s0_rvalid = rvalid;
        end
        if (rvalid && w_rready && rlast) begin
          w_next_state = IDLE;
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  assign arid    = r_grant ? s1_arid    : s0_arid;
  assign araddr  = r_grant ? s1_araddr  : s0_araddr;
  assign arlen   = r_grant ? s1_arlen   : s0_arlen;
  assign arsize  = r_grant ? s1_arsize  : s0_arsize;
  assign arburst = r_grant ? s1_arburst : s0_arburst;
  assign arlock  = r_grant ? s1_arlock  : s0_arlock;
  assign arcache = r_grant ? s1_arcache : s0_arcache;
  assign arprot  = r_grant ? s1_arprot  : s0_arprot;

  assign arvalid = w_arvalid;
  assign rready  = w_rready;
  assign grant   = r_grant;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: a behavioural AXI slave returns
// data = araddr + beat, and each master's expected beats are queued at issue.
module tb_axi_read_arbiter;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic              aclk;
  logic              rst;

  logic [ID_W-1:0]   s0_arid, s1_arid;
  logic [ADDR_W-1:0] s0_araddr, s1_araddr;
  logic [3:0]        s0_arlen, s1_arlen;
  logic [2:0]        s0_arsize, s1_arsize;
  logic [1:0]        s0_arburst, s1_arburst;
  logic [1:0]        s0_arlock, s1_arlock;
  logic [3:0]        s0_arcache, s1_arcache;
  logic [2:0]        s0_arprot, s1_arprot;
  logic              s0_arvalid, s1_arvalid;
  logic              s0_arready, s1_arready;
  logic [ID_W-1:0]   s0_rid, s1_rid;
  logic [DATA_W-1:0] s0_rdata, s1_rdata;
  logic [1:0]        s0_rresp, s1_rresp;
  logic              s0_rlast, s1_rlast;
  logic              s0_rvalid, s1_rvalid;
  logic              s0_rready, s1_rready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              grant;
  logic              busy;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  beat_t       expQ[2][$];
  logic [53:0] reqPay[2];
  bit          grantLog[$];
  int          beatCnt[2];
  int          rrMode = 0;
  int          slvArDelay = 0;
  bit          slvRandAr = 0;
  bit          slvGapEn = 0;
  bit          gapChkEn = 0;
  bit          haveLast = 0;
  int          lastBeatCyc = 0;

  axi_read_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .rst(rst),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .grant(grant), .busy(busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issues one read on master m: queue the expected beats, then hold arvalid until accepted.
  task automatic applyStimulus(input int m, input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len);
    logic [53:0] pay;
    bit ok;
    pay = {id, addr, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
           2'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
    reqPay[m] = pay;
    for (int i = 0; i <= int'(len); i++) begin
      expQ[m].push_back('{id: id, data: addr + 32'(i), resp: 2'(i), last: (i == int'(len))});
    end
    if (m == 0) begin
      {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot} = pay;
      s0_arvalid = 1'b1;
    end else begin
      {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot} = pay;
      s1_arvalid = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge aclk);
      if (!rst && ((m == 0) ? (s0_arvalid && s0_arready) : (s1_arvalid && s1_arready))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("ar_accept_timeout", 64'(0), 64'(1));
    @(posedge aclk);
    #1;
    if (m == 0) s0_arvalid = 1'b0;
    else        s1_arvalid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge aclk);
      if (expQ[0].size() == 0 && expQ[1].size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("drain_timeout", 64'(expQ[0].size() + expQ[1].size()), 64'(0));
      expQ[0].delete();
      expQ[1].delete();
    end
    @(posedge aclk);
    #1;
  endtask

  // Master-side rready: 0 = always ready, 1 = random, 2 = s0 toggles every cycle.
  initial begin
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rrMode)
        1: begin
          s0_rready = 1'($urandom_range(0, 1));
          s1_rready = 1'($urandom_range(0, 1));
        end
        2: begin
          s0_rready = ~s0_rready;
          s1_rready = 1'b1;
        end
        default: begin
          s0_rready = 1'b1;
          s1_rready = 1'b1;
        end
      endcase
    end
  end

  // Behavioural external slave: decides at the negedge, drives just after posedge.
  initial begin : slaveModel
    int          phase, waitCnt, beat;
    logic [3:0]  capId, capLen;
    logic [31:0] capAddr;
    bit          sRst, sArHs, sArv, sRHs;
    logic [3:0]  sId, sLen;
    logic [31:0] sAddr;
    phase = 0; waitCnt = 0; beat = 0;
    capId = '0; capLen = '0; capAddr = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    forever begin
      @(negedge aclk);
      sRst = rst; sArHs = arvalid && arready; sArv = arvalid; sRHs = rvalid && rready;
      sId = arid; sLen = arlen; sAddr = araddr;
      @(posedge aclk);
      #1;
      if (sRst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; phase = 0; waitCnt = 0;
      end else if (phase == 0) begin
        if (sArHs) begin
          arready = 1'b0; capId = sId; capLen = sLen; capAddr = sAddr;
          beat = 0; phase = 1; waitCnt = 0;
          if (slvRandAr) slvArDelay = $urandom_range(0, 3);
        end else if (sArv) begin
          if (waitCnt >= slvArDelay) arready = 1'b1;
          else waitCnt++;
        end else begin
          arready = 1'b0;
        end
      end else begin
        if (sRHs && rlast) begin
          rvalid = 1'b0; rlast = 1'b0; phase = 0;
        end else if (sRHs || !rvalid) begin
          if (sRHs) beat++;
          if (slvGapEn && $urandom_range(0, 3) == 0) begin
            rvalid = 1'b0;
          end else begin
            rvalid = 1'b1; rid = capId; rdata = capAddr + 32'(beat);
            rresp = 2'(beat); rlast = (beat == int'(capLen));
          end
        end
      end
    end
  end

  // Monitor: scoreboard pops plus per-cycle protocol checks.
  initial begin : monitor
    bit    prevArv;
    beat_t e;
    prevArv = 1'b0;
    forever begin
      @(negedge aclk);
      if (!rst) begin
        if (arvalid && arready) begin
          grantLog.push_back(grant);
          checkOutput("ar_payload",
                      64'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
                      64'(reqPay[grant]));
        end
        if (gapChkEn && haveLast && arvalid && !prevArv)
          checkOutput("ar_turnaround_cycles", 64'(cyc - lastBeatCyc), 64'(2));
        if (rvalid && rready && rlast) begin
          lastBeatCyc = cyc;
          haveLast = 1'b1;
        end
        if (!busy)
          checkOutput("idle_quiet", 64'({arvalid, rready, s0_rvalid, s1_rvalid}), 64'(0));
        else if (!arvalid)
          checkOutput("rready_mirror", 64'(rready), 64'(grant ? s1_rready : s0_rready));
        if (grant == 1'b0) begin
          if (s1_arvalid) checkOutput("held_off_arready_s1", 64'(s1_arready), 64'(0));
          if (busy) checkOutput("other_r_zero_s1",
                                64'({s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid}), 64'(0));
        end else begin
          if (s0_arvalid) checkOutput("held_off_arready_s0", 64'(s0_arready), 64'(0));
          if (busy) checkOutput("other_r_zero_s0",
                                64'({s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid}), 64'(0));
        end
        if (s0_rvalid && s0_rready) begin
          beatCnt[0]++;
          if (expQ[0].size() == 0) checkOutput("unexpected_beat_s0", 64'(1), 64'(0));
          else begin
            e = expQ[0].pop_front();
            checkOutput("r_beat_s0", 64'({s0_rid, s0_rdata, s0_rresp, s0_rlast}), 64'(e));
          end
        end
        if (s1_rvalid && s1_rready) begin
          beatCnt[1]++;
          if (expQ[1].size() == 0) checkOutput("unexpected_beat_s1", 64'(1), 64'(0));
          else begin
            e = expQ[1].pop_front();
            checkOutput("r_beat_s1", 64'({s1_rid, s1_rdata, s1_rresp, s1_rlast}), 64'(e));
          end
        end
      end
      prevArv = arvalid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int  base;
    bit  expFirst;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot} = '0;
    {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot} = '0;
    beatCnt[0] = 0; beatCnt[1] = 0;
    rst = 1'b1;
    @(posedge aclk);
    #1;

    // Reset with both masters requesting; first tie after reset goes to s0.
    fork
      applyStimulus(0, 4'h1, 32'h0000_1000, 4'd0);
      applyStimulus(1, 4'h2, 32'h0000_2000, 4'd0);
      begin
        repeat (3) begin
          @(negedge aclk);
          checkOutput("reset_outputs", 64'({arvalid, rready, s0_arready, s1_arready,
                                            s0_rvalid, s1_rvalid, busy, grant}), 64'(0));
        end
        @(posedge aclk);
        #1 rst = 1'b0;
        @(negedge aclk);
        checkOutput("arvalid_cycle_after_release", 64'(arvalid), 64'(0));
        @(negedge aclk);
        checkOutput("request_latency_arvalid", 64'(arvalid), 64'(1));
        checkOutput("first_grant_after_reset", 64'(grant), 64'(0));
      end
    join
    waitIdle(200);
    if (grantLog.size() < 2) checkOutput("reset_grant_count", 64'(grantLog.size()), 64'(2));
    else checkOutput("reset_grant_order", 64'({grantLog[0], grantLog[1]}), 64'(2'b01));

    // Single master s1, slave delays arready by 2 cycles.
    slvArDelay = 2;
    beatCnt[0] = 0; beatCnt[1] = 0;
    applyStimulus(1, 4'h3, 32'hBFC0_0000, 4'd3);
    waitIdle(200);
    checkOutput("single_s1_beats", 64'(beatCnt[1]), 64'(4));
    checkOutput("single_s0_beats", 64'(beatCnt[0]), 64'(0));
    checkOutput("single_back_idle", 64'(busy), 64'(0));

    // Round-robin: both masters request continuously with single-beat bursts.
    slvArDelay = 0;
    gapChkEn = 1'b1;
    haveLast = 1'b0;
    base = grantLog.size();
    expFirst = ~grantLog[base - 1];
    fork
      for (int k = 0; k < 4; k++) applyStimulus(0, 4'(k), 32'h0001_0000 + 32'(k * 16), 4'd0);
      for (int k = 0; k < 4; k++) applyStimulus(1, 4'(8 + k), 32'h0002_0000 + 32'(k * 16), 4'd0);
    join
    waitIdle(200);
    if (grantLog.size() != base + 8)
      checkOutput("rr_grant_count", 64'(grantLog.size() - base), 64'(8));
    else
      for (int k = 0; k < 8; k++)
        checkOutput("rr_grant_alternate", 64'(grantLog[base + k]), 64'(expFirst ^ k[0]));
    gapChkEn = 1'b0;

    // Backpressure: s0 8-beat burst with s0_rready toggling.
    beatCnt[0] = 0;
    rrMode = 2;
    applyStimulus(0, 4'h5, 32'h0000_0000, 4'd7);
    waitIdle(300);
    rrMode = 0;
    checkOutput("backpressure_beats", 64'(beatCnt[0]), 64'(8));

    // Late arrival: s1 raises arvalid while s0 is mid-burst.
    gapChkEn = 1'b1;
    haveLast = 1'b0;
    base = grantLog.size();
    fork
      applyStimulus(0, 4'h6, 32'h0000_3000, 4'd3);
      begin
        repeat (4) begin @(posedge aclk); #1; end
        applyStimulus(1, 4'h7, 32'h0000_4000, 4'd1);
      end
    join
    waitIdle(200);
    gapChkEn = 1'b0;
    if (grantLog.size() != base + 2)
      checkOutput("late_grant_count", 64'(grantLog.size() - base), 64'(2));
    else
      checkOutput("late_grant_order", 64'({grantLog[base], grantLog[base + 1]}), 64'(2'b01));

    // Reset pulsed mid-burst, then a fresh s1 request.
    beatCnt[0] = 0; beatCnt[1] = 0;
    applyStimulus(0, 4'h8, 32'h0000_5000, 4'd3);
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (beatCnt[0] >= 1) break;
    end
    @(posedge aclk);
    #1 rst = 1'b1;
    expQ[0].delete();
    @(posedge aclk);
    #1 rst = 1'b0;
    @(negedge aclk);
    checkOutput("mid_burst_reset_outputs", 64'({arvalid, rready, s0_arready, s1_arready,
                                                s0_rvalid, s1_rvalid, busy, grant}), 64'(0));
    @(posedge aclk);
    #1;
    applyStimulus(1, 4'h9, 32'h0000_6000, 4'd3);
    waitIdle(200);
    checkOutput("post_reset_s1_beats", 64'(beatCnt[1]), 64'(4));

    // Randomised traffic from both masters.
    rrMode = 1;
    slvGapEn = 1'b1;
    slvRandAr = 1'b1;
    fork
      for (int k = 0; k < 6; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
        applyStimulus(0, 4'($urandom_range(0, 15)), {$urandom} & 32'hFFFF_FFFC,
                      4'($urandom_range(0, 7)));
      end
      for (int k = 0; k < 6; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
        applyStimulus(1, 4'($urandom_range(0, 15)), {$urandom} & 32'hFFFF_FFFC,
                      4'($urandom_range(0, 7)));
      end
    join
    waitIdle(3000);
    rrMode = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master AXI3 read-channel arbiter that shares the core's single external AR/R port between the data cache (master 0) and the instruction cache (master 1). It replaces the generated crossbar on the read path, and sits between the two caches' AR/R ports and the top-level `ar*`/`r*` pins. One transaction is outstanding at a time. Masters alternate round-robin, and each granted burst runs to `rlast` before re-arbitration.

## Interface
Parameters:
- `ID_W`, default 4: AXI ID width.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `aclk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `s0_ar{id,addr,len,size,burst,lock,cache,prot}` and `s1_ar{…}`, in, AXI3 widths (`ID_W`, `ADDR_W`, 4, 3, 2, 2, 4, 3): AR payload from the data cache (s0) and the instruction cache (s1).
- `s0_arvalid`, `s1_arvalid`, in, 1: read request from each master.
- `s0_arready`, `s1_arready`, out, 1: AR accept to each master.
- `s0_r{id,data,resp,last,valid}` and `s1_r{…}`, out, (`ID_W`, `DATA_W`, 2, 1, 1): R channel routed back to each master.
- `s0_rready`, `s1_rready`, in, 1: R accept from each master.
- `ar{id,addr,len,size,burst,lock,cache,prot}`, out, AXI3 widths: AR payload to the external port.
- `arvalid`, out, 1: external AR valid.
- `arready`, in, 1: external AR accept.
- `r{id,data,resp,last,valid}`, in: external R channel.
- `rready`, out, 1: external R accept.
- `grant`, out, 1: currently or last granted master index (debug).
- `busy`, out, 1: high in ADDR and DATA.

## Operation
- States: IDLE, ADDR, DATA. Encoding is held in the shared package.
- **IDLE**
  - No request: stay in IDLE.
  - Any `sN_arvalid` high: register the winner into `grant` and go to ADDR.
  - Tie: the master not granted last time wins.
  - First tie after reset: master 0 wins (`last_grant` resets to 1).
- **ADDR**
  - AR payload and `arvalid` are muxed combinationally from the granted master.
  - `s<grant>_arready = arready`; the other master's `arready` is 0.
  - On `arvalid && arready`, go to DATA.
  - Granted master drops `arvalid` before the handshake: protocol violation. Forward `arvalid` low and stay in ADDR; no re-arbitration.
- **DATA**
  - External R payload and `rvalid` go to the granted master only.
  - `rready = s<grant>_rready`.
  - The other master sees `rvalid` = 0; its R payload is driven to 0.
  - On `rvalid && rready && rlast`: set `last_grant = grant` and go to IDLE.
  - `rid` and `rresp` are passed through unchecked.
- The ungranted master's request is held off (`arready` = 0) until the current burst completes. It is never dropped.
- The write channel is outside this block.

## Timing
- Reset values: `arvalid`=0, `rready`=0, `s0/s1_arready`=0, `s0/s1_rvalid`=0, `grant`=0, `busy`=0, state=IDLE, `last_grant`=1.
- Request latency: `sN_arvalid` first seen in cycle T → `arvalid` high in cycle T+1. Grant is registered; the output path is combinational from the granted inputs.
- Turnaround: handshake of the last beat in cycle T → IDLE in T+1 → earliest next `arvalid` in T+2.
- No combinational path from `arready` to `arvalid`, or from `rvalid` to `rready`.
- A request arriving on the other master while a burst is in flight wins the next arbitration. It is granted in the cycle after the return to IDLE.
- `rst` mid-burst: next cycle is IDLE with all outputs at reset values. The external slave is reset by the same reset; no beat draining.
- `arlen` = 0 (single beat): ADDR → DATA → IDLE. The first beat must carry `rlast`.

## Structure
- Package `axi_arb_pkg`:
  - state enum {IDLE, ADDR, DATA};
  - AXI3 field widths (LEN_W=4, SIZE_W=3, BURST_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3, RESP_W=2).
- Sub-module `rr_arb2`: inputs `req[1:0]`, `last_grant`; output `winner`. Combinational round-robin pick.
- Top level: FSM, `grant`/`last_grant` registers, AR mux, R demux.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with both `arvalid`=1 → all valids/readies 0, `busy`=0; first grant after release is master 0.
- **Single master:** s1 requests `araddr`=0xBFC00000, `arlen`=3, slave `arready` delayed 2 cycles, 4 beats → s1 gets exactly 4 beats with `rlast` on beat 4; s0 `rvalid` stays 0; back to IDLE.
- **Round-robin:** both request continuously, 1-beat bursts → grants alternate 0,1,0,1 over 8 transactions; each AR issued 2 cycles after the previous last beat.
- **Backpressure:** s0 granted, `arlen`=7, `s0_rready` toggling 1,0,1,0 → `rready` mirrors it; no beat lost or duplicated (check 8 data values 0x0…0x7).
- **Late arrival:** s0 mid-burst when s1 raises `arvalid` → s1 `arready` stays 0 until s0's `rlast` handshake; s1 `arvalid` out exactly 2 cycles later.
- **Reset mid-burst:** `rst` pulsed during beat 2 of 4 → next cycle IDLE, outputs 0; a fresh s1 request completes normally.
